// File: rtl/pulse_generator_pkg.sv
// Shared constants and helpers for strobe/tick generators.
package pulse_generator_pkg;

   // Smallest period that still leaves at least one low cycle between pulses.
   localparam int MIN_INTERVAL = 2;

   // Counter width needed to hold 0 .. interval-1 (never less than one bit).
   function automatic int cnt_width(input int interval);
      int w;
      w = $clog2(interval);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/pulse_generator.sv
// Free-running strobe generator: one-cycle high pulse on out every INTERVAL
// clocks. Intended as a tick/enable source (e.g. UART baud/oversample ticks).
// Counter plus registered output; out has no combinational path from rst.
module pulse_generator
   import pulse_generator_pkg::*;
#(
   parameter int INTERVAL = 16
) (
   input  logic clk,
   input  logic rst,
   output logic out
);

   localparam int CNT_W = cnt_width(INTERVAL);
   // Terminal count; wrap is an explicit compare-and-clear so non-power-of-2
   // periods (e.g. 3) are exact.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERVAL - 1);

   // Reject periods too short to form a strobe.
   if (INTERVAL < MIN_INTERVAL) begin : g_bad_interval
      $error("pulse_generator: INTERVAL must be >= 2");
   end

   logic [CNT_W-1:0] count;

   // Count clocks since reset; raise out for the single cycle after the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         out   <= 1'b0;
      end else if (count == LAST) begin
         count <= '0;
         out   <= 1'b1;
      end else begin
         count <= count + CNT_W'(1);
         out   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: INTERVAL=3 and INTERVAL=16 instances sharing
// clk/rst. Expected strobes come from a cycles-since-release model:
// out is high exactly after edges that are positive multiples of INTERVAL.
module tb_pulse_generator;

   localparam int I_A = 3;
   localparam int I_B = 16;

   logic clk;
   logic rst;
   logic out_a;
   logic out_b;

   int total = 0;
   int bad   = 0;

   // Edges with rst=0 since the last reset edge.
   int n_since = 0;

   pulse_generator #(.INTERVAL(I_A)) dut_a (.clk(clk), .rst(rst), .out(out_a));
   pulse_generator #(.INTERVAL(I_B)) dut_b (.clk(clk), .rst(rst), .out(out_b));

   // Clock / reset block.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog over the whole run.
   initial begin
      #200us;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic observed, input logic expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s cycle_since_release=%0d observed=%b expected=%b",
                tag, n_since, observed, expected);
      end
   endtask

   // Drive rst for one edge, advance the model, then compare both instances.
   task automatic step(input logic r, input string tag);
      logic exp_a;
      logic exp_b;
      rst = r;
      @(posedge clk);
      if (r) n_since = 0;
      else   n_since = n_since + 1;
      exp_a = !r && (n_since % I_A == 0);
      exp_b = !r && (n_since % I_B == 0);
      #1;
      check({tag, "_a"}, out_a, exp_a);
      check({tag, "_b"}, out_b, exp_b);
   endtask

   task automatic run(input int cycles, input logic r, input string tag);
      for (int i = 0; i < cycles; i++) step(r, tag);
   endtask

   initial begin
      rst = 1'b1;

      // Held reset: both outputs stay low.
      run(100, 1'b1, "hold_rst");

      // Free run: 10 periods of the slow instance covers >10 of the fast one.
      run(10 * I_B, 1'b0, "free_run");

      // Reset mid-period at count=1, then a fresh full period.
      step(1'b1, "mid_rst_pre");
      step(1'b0, "mid_cnt1");
      step(1'b1, "mid_rst");
      run(3 * I_B, 1'b0, "mid_after");

      // Reset on the slow instance's pulse cycle.
      step(1'b1, "pulse_rst_pre");
      run(I_B, 1'b0, "to_pulse_b");
      step(1'b1, "pulse_rst_b");
      run(2 * I_B, 1'b0, "after_pulse_b");

      // Reset on the fast instance's pulse cycle.
      step(1'b1, "pulse_rst_pre2");
      run(I_A, 1'b0, "to_pulse_a");
      step(1'b1, "pulse_rst_a");
      run(2 * I_B, 1'b0, "after_pulse_a");

      // Random sparse resets.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 39) == 0), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
